// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int SA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    // Counter must be able to hold WIDTH itself, hence WIDTH+1 codes.
    function automatic int sa_cnt_width(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sa_full_adder_bit.sv
// One-bit full adder: two cascaded half adders with the carries ORed together.
module sa_full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    assign ha0_sum   = a ^ b;
    assign ha0_carry = a & b;

    assign sum       = ha0_sum ^ cin;
    assign ha1_carry = ha0_sum & cin;

    assign cout      = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, result held until next start.
// Optional SERIAL_ADDER_OVF_EN adds the sa_ovf signed-overflow output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             sa_clk,
    input  logic             sa_rst_n,
    input  logic             sa_start,
    input  logic [WIDTH-1:0] sa_A,
    input  logic [WIDTH-1:0] sa_B,
    output logic             sa_busy,
    output logic             sa_done,
    output logic [WIDTH-1:0] sa_S,
    output logic             sa_C
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             sa_ovf
`endif
);

    localparam int CNT_W = sa_cnt_width(WIDTH);

    sa_state_t        state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] s_reg, s_next;
    logic             carry_reg, carry_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH:0]   s_shift;
    logic             sum_bit;
    logic             carry_bit;
    logic             start_accept;
    logic             last_bit;

    assign start_accept = (state_reg == IDLE) && sa_start;
    assign last_bit     = (state_reg == RUN) && (cnt_reg == CNT_W'(WIDTH - 1));
    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at position 0.
    assign s_shift      = {sum_bit, s_reg};

    sa_full_adder_bit u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry_reg),
        .sum  (sum_bit),
        .cout (carry_bit)
    );

    // State register
    always_ff @(posedge sa_clk or negedge sa_rst_n) begin
        if (!sa_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sa_start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        sa_busy = 1'b0;
        sa_done = 1'b0;
        case (state_reg)
            RUN:     sa_busy = 1'b1;
            DONE:    sa_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: load on accepted start, shift/add while running, hold otherwise.
    always_comb begin
        a_next     = a_reg;
        b_next     = b_reg;
        s_next     = s_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        if (start_accept) begin
            a_next     = sa_A;
            b_next     = sa_B;
            s_next     = '0;
            carry_next = 1'b0;
            cnt_next   = '0;
        end else if (state_reg == RUN) begin
            a_next     = a_reg >> 1;
            b_next     = b_reg >> 1;
            s_next     = s_shift[WIDTH:1];
            carry_next = carry_bit;
            cnt_next   = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge sa_clk or negedge sa_rst_n) begin
        if (!sa_rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            a_reg     <= a_next;
            b_reg     <= b_next;
            s_reg     <= s_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign sa_S = s_reg;
    // After the last bit the carry flop holds the MSB carry-out and is frozen until the next start.
    assign sa_C = carry_reg;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_reg, ovf_next;

    // On the final bit carry_reg is the carry into the MSB and carry_bit the carry out of it.
    always_comb begin
        ovf_next = ovf_reg;
        if (start_accept) begin
            ovf_next = 1'b0;
        end else if (last_bit) begin
            ovf_next = carry_reg ^ carry_bit;
        end
    end

    always_ff @(posedge sa_clk or negedge sa_rst_n) begin
        if (!sa_rst_n) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
        end
    end

    assign sa_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 main instance plus a WIDTH=1 corner instance).
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       w1_start;
    logic [0:0] w1_a;
    logic [0:0] w1_b;
    logic       w1_busy;
    logic       w1_done;
    logic [0:0] w1_s;
    logic       w1_c;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
    logic       w1_ovf;
`endif

    int compared   = 0;
    int mismatched = 0;

    serial_adder #(.WIDTH(8)) dut (
        .sa_clk   (clk),
        .sa_rst_n (rst_n),
        .sa_start (start),
        .sa_A     (op_a),
        .sa_B     (op_b),
        .sa_busy  (busy),
        .sa_done  (done),
        .sa_S     (sum),
        .sa_C     (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .sa_ovf   (ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) dut_w1 (
        .sa_clk   (clk),
        .sa_rst_n (rst_n),
        .sa_start (w1_start),
        .sa_A     (w1_a),
        .sa_B     (w1_b),
        .sa_busy  (w1_busy),
        .sa_done  (w1_done),
        .sa_S     (w1_s),
        .sa_C     (w1_c)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .sa_ovf   (w1_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete 8-bit operation with latency, busy-length and result checks.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input string tag);
        int         n;
        int         busy_cnt;
        logic       got;
        logic [8:0] ref_sum;
        int         ssum;
        ref_sum = {1'b0, a} + {1'b0, b};
        ssum    = int'($signed(a)) + int'($signed(b));
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        tick();
        start    = 1'b0;
        op_a     = 8'($urandom);
        op_b     = 8'($urandom);
        busy_cnt = busy ? 1 : 0;
        n        = 0;
        got      = 1'b0;
        while (n < 40 && !got) begin
            tick();
            n++;
            if (done) got = 1'b1;
            else if (busy) busy_cnt++;
        end
        $display("op %s: A=%02h B=%02h S=%02h C=%0d latency=%0d", tag, a, b, sum, cout, n);
        chk($sformatf("%s latency", tag), 32'(n), 32'd8);
        chk($sformatf("%s busy_cycles", tag), 32'(busy_cnt), 32'd8);
        chk($sformatf("%s busy_in_done", tag), 32'(busy), 32'd0);
        chk($sformatf("%s S", tag), 32'(sum), 32'(ref_sum[7:0]));
        chk($sformatf("%s C", tag), 32'(cout), 32'(ref_sum[8]));
`ifdef SERIAL_ADDER_OVF_EN
        chk($sformatf("%s ovf", tag), 32'(ovf), 32'((ssum > 127 || ssum < -128) ? 1 : 0));
`endif
        tick();
        chk($sformatf("%s done_pulse", tag), 32'(done), 32'd0);
        chk($sformatf("%s S_held", tag), 32'(sum), 32'(ref_sum[7:0]));
    endtask

    initial begin
        logic [15:0] pending[$];
        logic [15:0] ops;
        logic [8:0]  ref_sum;
        int          n;
        int          pulses;
        logic        got;
        logic [7:0]  ra;
        logic [7:0]  rb;

        rst_n    = 1'b0;
        start    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        w1_start = 1'b0;
        w1_a     = '0;
        w1_b     = '0;

        // Reset state
        repeat (3) tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst S", 32'(sum), 32'd0);
        chk("rst C", 32'(cout), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst busy", 32'(busy), 32'd0);
        chk("post_rst S", 32'(sum), 32'd0);

        // Directed vectors
        run8(8'h03, 8'h05, "add_03_05");
        run8(8'hFF, 8'h01, "add_FF_01");
        run8(8'h7F, 8'h01, "add_7F_01");
        run8(8'h80, 8'h80, "add_80_80");

        // Starts during RUN and DONE must be ignored
        start = 1'b1;
        op_a  = 8'h10;
        op_b  = 8'h20;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        op_a  = 8'hFF;
        op_b  = 8'hFF;
        tick();
        start = 1'b0;
        n     = 3;
        got   = 1'b0;
        while (n < 40 && !got) begin
            if (done) got = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        $display("op ignore_run: S=%02h C=%0d latency=%0d", sum, cout, n);
        chk("ignore latency", 32'(n), 32'd8);
        chk("ignore S", 32'(sum), 32'h30);
        chk("ignore C", 32'(cout), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ignore_done busy", 32'(busy), 32'd0);
        chk("ignore_done done", 32'(done), 32'd0);
        pulses = 0;
        repeat (12) begin
            tick();
            if (done || busy) pulses++;
        end
        $display("op ignore_done: S=%02h C=%0d extra_activity=%0d", sum, cout, pulses);
        chk("ignore extra_activity", 32'(pulses), 32'd0);
        chk("ignore S_held", 32'(sum), 32'h30);

        // Asynchronous reset in the middle of an operation
        start = 1'b1;
        op_a  = 8'hAA;
        op_b  = 8'h55;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1;
        $display("op mid_reset: busy=%0d done=%0d S=%02h C=%0d", busy, done, sum, cout);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst S", 32'(sum), 32'd0);
        chk("midrst C", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("midrst ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst idle", 32'(busy), 32'd0);
        run8(8'h01, 8'h01, "after_reset");

        // Continuous start: accepted every WIDTH+2 edges
        for (int t = 0; t < 60; t++) begin
            start = 1'b1;
            op_a  = 8'($urandom);
            op_b  = 8'($urandom);
            if (t % 10 == 0) pending.push_back({op_a, op_b});
            tick();
            chk($sformatf("cont t=%0d done", t), 32'(done), 32'((t % 10 == 8) ? 1 : 0));
            if (done && pending.size() > 0) begin
                ops     = pending.pop_front();
                ref_sum = {1'b0, ops[15:8]} + {1'b0, ops[7:0]};
                $display("op cont t=%0d: A=%02h B=%02h S=%02h C=%0d", t, ops[15:8], ops[7:0], sum, cout);
                chk($sformatf("cont t=%0d S", t), 32'(sum), 32'(ref_sum[7:0]));
                chk($sformatf("cont t=%0d C", t), 32'(cout), 32'(ref_sum[8]));
            end
        end
        start = 1'b0;
        tick();

        // Random single operations
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, $sformatf("rand%0d", i));
        end

        // WIDTH=1 corner
        w1_start = 1'b1;
        w1_a     = 1'b1;
        w1_b     = 1'b1;
        tick();
        w1_start = 1'b0;
        w1_a     = 1'b0;
        w1_b     = 1'b0;
        chk("w1 busy", 32'(w1_busy), 32'd1);
        n   = 0;
        got = 1'b0;
        while (n < 10 && !got) begin
            tick();
            n++;
            if (w1_done) got = 1'b1;
        end
        $display("op w1 1+1: S=%0d C=%0d latency=%0d", w1_s, w1_c, n);
        chk("w1 latency", 32'(n), 32'd1);
        chk("w1 S", 32'(w1_s), 32'd0);
        chk("w1 C", 32'(w1_c), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("w1 ovf", 32'(w1_ovf), 32'd1);
`endif
        tick();
        chk("w1 done_pulse", 32'(w1_done), 32'd0);
        w1_start = 1'b1;
        w1_a     = 1'b1;
        w1_b     = 1'b0;
        tick();
        w1_start = 1'b0;
        tick();
        $display("op w1 1+0: S=%0d C=%0d done=%0d", w1_s, w1_c, w1_done);
        chk("w1b done", 32'(w1_done), 32'd1);
        chk("w1b S", 32'(w1_s), 32'd1);
        chk("w1b C", 32'(w1_c), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
